// File: rtl/board_renderer.sv
// Tetris board rasteriser: snapshots board and falling piece at frame start, then
// streams one plot command per clock (rows, columns, dy, dx) to the frame buffer.
module board_renderer #(
  parameter int unsigned CELL_SIZE   = 4,
  parameter int unsigned ORIGIN_X    = 60,
  parameter int unsigned ORIGIN_Y    = 20,
  parameter int unsigned HIDDEN_ROWS = 3
) (
  input  logic         clk_50,
  input  logic         resetn,
  input  logic         start,
  input  logic [229:0] board_value,
  input  logic         show_falling,
  input  logic [3:0]   t0_x,
  input  logic [3:0]   t1_x,
  input  logic [3:0]   t2_x,
  input  logic [3:0]   t3_x,
  input  logic [4:0]   t0_y,
  input  logic [4:0]   t1_y,
  input  logic [4:0]   t2_y,
  input  logic [4:0]   t3_y,
  input  logic         gameover,
  output logic [7:0]   x,
  output logic [6:0]   y,
  output logic [2:0]   colour,
  output logic         plot,
  output logic         busy,
  output logic         done
);

  localparam int unsigned DW       = (CELL_SIZE > 1) ? $clog2(CELL_SIZE) : 1;
  localparam int unsigned LAST_ROW = 22;
  localparam int unsigned LAST_COL = 9;

  typedef enum logic [1:0] {S_IDLE, S_LATCH, S_DRAW, S_DONE} state_t;

  state_t         r_state;
  logic [229:0]   r_board;
  logic [3:0]     r_tx [4];
  logic [4:0]     r_ty [4];
  logic           r_show;
  logic           r_go;
  logic [4:0]     r_row;
  logic [3:0]     r_col;
  logic [DW-1:0]  r_dy;
  logic [DW-1:0]  r_dx;

  logic [7:0]     w_idx;
  logic           w_stacked;
  logic           w_falling;
  logic [2:0]     w_colour;
  logic           w_last_dx;
  logic           w_last_dy;
  logic           w_last_col;
  logic           w_last_row;

  // Column c of row r lives at bit r*10 + (9-c).
  assign w_idx     = 8'(r_row) * 8'd10 + 8'd9 - 8'(r_col);
  assign w_stacked = r_board[w_idx];

  always_comb begin
    w_falling = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (r_show && (r_tx[i] == r_col) && (r_ty[i] == r_row)) w_falling = 1'b1;
    end
  end

  assign w_colour   = w_falling ? 3'b110 :
                      w_stacked ? (r_go ? 3'b100 : 3'b111) : 3'b000;
  assign w_last_dx  = (r_dx == DW'(CELL_SIZE - 1));
  assign w_last_dy  = (r_dy == DW'(CELL_SIZE - 1));
  assign w_last_col = (r_col == 4'(LAST_COL));
  assign w_last_row = (r_row == 5'(LAST_ROW));

  always_ff @(posedge clk_50 or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_board <= '0;
      for (int i = 0; i < 4; i++) begin
        r_tx[i] <= '0;
        r_ty[i] <= '0;
      end
      r_show  <= 1'b0;
      r_go    <= 1'b0;
      r_row   <= '0;
      r_col   <= '0;
      r_dy    <= '0;
      r_dx    <= '0;
      x       <= '0;
      y       <= '0;
      colour  <= '0;
      plot    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_state <= S_LATCH;
            busy    <= 1'b1;
          end
        end
        S_LATCH: begin
          r_board <= board_value;
          r_tx[0] <= t0_x;
          r_tx[1] <= t1_x;
          r_tx[2] <= t2_x;
          r_tx[3] <= t3_x;
          r_ty[0] <= t0_y;
          r_ty[1] <= t1_y;
          r_ty[2] <= t2_y;
          r_ty[3] <= t3_y;
          r_show  <= show_falling;
          r_go    <= gameover;
          r_row   <= 5'(HIDDEN_ROWS);
          r_col   <= '0;
          r_dy    <= '0;
          r_dx    <= '0;
          r_state <= S_DRAW;
        end
        S_DRAW: begin
          // Coordinates are formed at 9 bits and wrap into the narrower outputs.
          plot   <= 1'b1;
          colour <= w_colour;
          x      <= 8'(9'(ORIGIN_X) + 9'(r_col) * 9'(CELL_SIZE) + 9'(r_dx));
          y      <= 7'(9'(ORIGIN_Y) + (9'(r_row) - 9'(HIDDEN_ROWS)) * 9'(CELL_SIZE)
                       + 9'(r_dy));
          if (!w_last_dx) begin
            r_dx <= r_dx + DW'(1);
          end else begin
            r_dx <= '0;
            if (!w_last_dy) begin
              r_dy <= r_dy + DW'(1);
            end else begin
              r_dy <= '0;
              if (!w_last_col) begin
                r_col <= r_col + 4'd1;
              end else begin
                r_col <= '0;
                if (w_last_row) r_state <= S_DONE;
                else            r_row   <= r_row + 5'd1;
              end
            end
          end
        end
        S_DONE: begin
          plot    <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_board_renderer.sv
// Directed bench for board_renderer: a frame-level model predicts every plotted pixel,
// with literal checks on timing, frame corners and selected screen cells.
`timescale 1ns/1ps
module tb_board_renderer;

  typedef struct packed {
    logic [7:0] px;
    logic [6:0] py;
    logic [2:0] pc;
  } pix_t;

  logic         clk_50 = 1'b0;
  logic         resetn;
  logic         start;
  logic         start2;
  logic [229:0] board_value;
  logic         show_falling;
  logic [3:0]   tx [4];
  logic [4:0]   ty [4];
  logic         gameover;
  logic [7:0]   x, x2;
  logic [6:0]   y, y2;
  logic [2:0]   colour, colour2;
  logic         plot, plot2, busy, busy2, done, done2;

  int n_checks = 0;
  int n_err    = 0;
  pix_t exp_q[$];
  pix_t exp_q2[$];
  pix_t e1, e2;
  logic [2:0] scr [256][128];

  always #10 clk_50 = ~clk_50;

  board_renderer dut (
    .clk_50(clk_50), .resetn(resetn), .start(start), .board_value(board_value),
    .show_falling(show_falling),
    .t0_x(tx[0]), .t1_x(tx[1]), .t2_x(tx[2]), .t3_x(tx[3]),
    .t0_y(ty[0]), .t1_y(ty[1]), .t2_y(ty[2]), .t3_y(ty[3]),
    .gameover(gameover), .x(x), .y(y), .colour(colour),
    .plot(plot), .busy(busy), .done(done)
  );

  board_renderer #(.CELL_SIZE(2), .ORIGIN_X(0), .ORIGIN_Y(0), .HIDDEN_ROWS(0)) dut2 (
    .clk_50(clk_50), .resetn(resetn), .start(start2), .board_value(board_value),
    .show_falling(show_falling),
    .t0_x(tx[0]), .t1_x(tx[1]), .t2_x(tx[2]), .t3_x(tx[3]),
    .t0_y(ty[0]), .t1_y(ty[1]), .t2_y(ty[2]), .t3_y(ty[3]),
    .gameover(gameover), .x(x2), .y(y2), .colour(colour2),
    .plot(plot2), .busy(busy2), .done(done2)
  );

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Frame model: every visible cell expands to a CELL x CELL block of one colour.
  task automatic build(input logic [229:0] b, input logic sf, input logic go,
                       input int cs, input int ox, input int oy, input int hr,
                       input bit second);
    for (int r = hr; r < 23; r++) begin
      for (int c = 0; c < 10; c++) begin
        logic [2:0] col;
        bit fall;
        fall = 0;
        for (int i = 0; i < 4; i++)
          if (sf && int'(tx[i]) == c && int'(ty[i]) == r) fall = 1;
        if (fall)                col = 3'b110;
        else if (b[r*10 + 9 - c]) col = go ? 3'b100 : 3'b111;
        else                     col = 3'b000;
        for (int dy = 0; dy < cs; dy++) begin
          for (int dx = 0; dx < cs; dx++) begin
            pix_t p;
            p.px = 8'(ox + c*cs + dx);
            p.py = 7'(oy + (r-hr)*cs + dy);
            p.pc = col;
            if (second) exp_q2.push_back(p);
            else        exp_q.push_back(p);
          end
        end
      end
    end
  endtask

  // Pixel compare: every plot strobe of either instance is checked against the model.
  always @(negedge clk_50) begin
    if (plot) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL pix_extra: got plot at x=%0d y=%0d, expected no plot", x, y);
      end else begin
        e1 = exp_q.pop_front();
        if ({x, y, colour} != e1) begin
          n_err++;
          $display("FAIL pix: got x=%0d y=%0d c=%0d, expected x=%0d y=%0d c=%0d",
                   x, y, colour, e1.px, e1.py, e1.pc);
        end
        scr[x][y] = colour;
      end
    end
    if (plot2) begin
      n_checks++;
      if (exp_q2.size() == 0) begin
        n_err++;
        $display("FAIL pix2_extra: got plot at x=%0d y=%0d, expected no plot", x2, y2);
      end else begin
        e2 = exp_q2.pop_front();
        if ({x2, y2, colour2} != e2) begin
          n_err++;
          $display("FAIL pix2: got x=%0d y=%0d c=%0d, expected x=%0d y=%0d c=%0d",
                   x2, y2, colour2, e2.px, e2.py, e2.pc);
        end
      end
    end
  end

  task automatic frame(input int inv_at, input int start_at, input int rst_at);
    int n, nplot, first, last, dcyc, ndone, fx, fy, lx, ly;
    for (int i = 0; i < 256; i++)
      for (int j = 0; j < 128; j++) scr[i][j] = 3'bxxx;
    build(board_value, show_falling, gameover, 4, 60, 20, 3, 1'b0);
    @(negedge clk_50); start = 1'b1;
    @(negedge clk_50); start = 1'b0;
    n = 0; nplot = 0; first = -1; last = -1; dcyc = -1; ndone = 0;
    fx = 0; fy = 0; lx = 0; ly = 0;
    while (n < 4000) begin
      @(negedge clk_50);
      n++;
      if (plot) begin
        nplot++;
        if (first < 0) begin first = n; fx = int'(x); fy = int'(y); end
        last = n; lx = int'(x); ly = int'(y);
      end
      if (done) begin ndone++; dcyc = n; end
      if (n == 1) chk("busy_latch", int'(busy), 1);
      if (n == inv_at) board_value = ~board_value;
      start = (n == start_at);
      if (n == rst_at) begin
        resetn = 1'b0;
        #1;
        chk("rst_plot", int'(plot), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        exp_q.delete();
        repeat (3) @(negedge clk_50);
        resetn = 1'b1;
        repeat (4) begin
          @(negedge clk_50);
          chk("rst_no_done", int'(done), 0);
        end
        return;
      end
      if (dcyc >= 0 && n >= dcyc + 6) break;
    end
    chk("done_seen", int'(dcyc >= 0), 1);
    chk("plots", nplot, 3200);
    chk("first_cyc", first, 2);
    chk("first_x", fx, 60);
    chk("first_y", fy, 20);
    chk("last_cyc", last, 3201);
    chk("last_x", lx, 99);
    chk("last_y", ly, 99);
    chk("done_cyc", dcyc, 3202);
    chk("done_count", ndone, 1);
    chk("busy_after", int'(busy), 0);
    chk("model_drained", exp_q.size(), 0);
  endtask

  task automatic frame2();
    int n, nplot, last, dcyc, lx, ly;
    build(board_value, show_falling, gameover, 2, 0, 0, 0, 1'b1);
    @(negedge clk_50); start2 = 1'b1;
    @(negedge clk_50); start2 = 1'b0;
    n = 0; nplot = 0; last = -1; dcyc = -1; lx = 0; ly = 0;
    while (n < 1500) begin
      @(negedge clk_50);
      n++;
      if (plot2) begin nplot++; last = n; lx = int'(x2); ly = int'(y2); end
      if (done2 && dcyc < 0) dcyc = n;
      if (dcyc >= 0 && n >= dcyc + 4) break;
    end
    chk("p2_plots", nplot, 920);
    chk("p2_last_cyc", last, 921);
    chk("p2_last_x", lx, 19);
    chk("p2_last_y", ly, 45);
    chk("p2_done_cyc", dcyc, 922);
    chk("p2_drained", exp_q2.size(), 0);
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; start2 = 1'b0; board_value = '0;
    show_falling = 1'b0; gameover = 1'b0;
    for (int i = 0; i < 4; i++) begin tx[i] = '0; ty[i] = '0; end
    repeat (3) @(negedge clk_50);
    chk("reset_x", int'(x), 0);
    chk("reset_y", int'(y), 0);
    chk("reset_colour", int'(colour), 0);
    chk("reset_plot", int'(plot), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    resetn = 1'b1;
    @(negedge clk_50);

    frame(-1, -1, -1);
    chk("t1_scr", int'(scr[80][60]), 0);

    board_value[229] = 1'b1;
    frame(-1, -1, -1);
    chk("t2_in_a", int'(scr[60][96]), 7);
    chk("t2_in_b", int'(scr[63][99]), 7);
    chk("t2_out_x", int'(scr[64][99]), 0);
    chk("t2_out_y", int'(scr[60][95]), 0);
    gameover = 1'b1;
    frame(-1, -1, -1);
    chk("t2_go", int'(scr[61][97]), 4);
    gameover = 1'b0;

    board_value = '0;
    board_value[55] = 1'b1; board_value[54] = 1'b1;
    board_value[65] = 1'b1; board_value[64] = 1'b1;
    show_falling = 1'b1;
    tx[0] = 4'd4; ty[0] = 5'd5; tx[1] = 4'd5; ty[1] = 5'd5;
    tx[2] = 4'd4; ty[2] = 5'd6; tx[3] = 4'd5; ty[3] = 5'd6;
    frame(-1, -1, -1);
    chk("t3_fall_a", int'(scr[76][28]), 6);
    chk("t3_fall_b", int'(scr[83][35]), 6);
    chk("t3_out", int'(scr[84][35]), 0);
    ty[3] = 5'd1;
    frame(-1, -1, -1);
    chk("t3_hidden_tile", int'(scr[80][32]), 7);
    chk("t3_still_fall", int'(scr[76][32]), 6);
    show_falling = 1'b0;

    board_value = {23{10'b1010011001}};
    frame(50, 100, -1);
    chk("t4_snap_c0", int'(scr[60][20]), 7);
    chk("t4_snap_c1", int'(scr[64][20]), 0);

    board_value = '0;
    frame(-1, -1, 1000);
    frame(-1, -1, -1);

    board_value[229] = 1'b1;
    frame2();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
